univ_shift_reg: RTL
===================

# univ_shift_reg

Parametrised universal shift register: the next generation of the enabled D register, widened to a WIDTH-bit word with parallel load and multi-cycle logical/arithmetic shift and rotate commands. A command is issued with a single-cycle start strobe and runs one bit-position per enabled clock. Busy and done flags report progress. The block sits in datapaths that serialise, deserialise or scale words under a controller.

## Interface
- WIDTH, 8, data word width (≥2)
- AMT_W, $clog2(WIDTH)+1, width of the shift-amount input
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  clock enable for shift steps; low freezes a running command
- start  in  1  command strobe, sampled only in IDLE
- op  in  3  command code (see Operation), sampled with start
- amt  in  AMT_W  number of one-bit steps, sampled with start
- d  in  WIDTH  parallel load data, sampled with start
- si  in  1  serial input for SHL/SHR, sampled at each step edge
- q  out  WIDTH  register contents
- so  out  1  last bit shifted or rotated out
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse

## Operation
- op codes: 0 HOLD, 1 LOAD, 2 SHL (si into bit 0), 3 SHR (si into bit WIDTH-1), 4 ROL, 5 ROR, 6 ASR (MSB replicated). Codes 7 and above behave as HOLD.
- FSM states: IDLE and RUN.
- IDLE, start=1, op=LOAD: q<=d at the sampling edge; next state IDLE; done pulses. en is not required.
- IDLE, start=1, op=HOLD/illegal or amt=0: no change to q or so; done pulses; busy stays 0.
- IDLE, start=1, shift op with amt>0: latch op and cnt<=amt; go to RUN; q unchanged at that edge.
- RUN, en=1: one step on q, so<=the bit shifted out, cnt<=cnt-1. When cnt was 1, go to IDLE and pulse done.
- RUN, en=0: q, so and cnt hold; the state stays RUN.
- start while busy is ignored. op, amt, d and si changes during RUN do not affect the latched command; si is still sampled live at each step.
- amt > WIDTH is legal. Shifts saturate naturally: q becomes all si for SHL/SHR and all sign bit for ASR. Rotates wrap modulo WIDTH.
- Reset at any time, including mid-command: q=0, so=0, busy=0, done=0, cnt=0, state IDLE. The command is abandoned and no done is issued.

## Timing
- Let the start-sampling edge be E0.
- LOAD, HOLD, or amt=0: done=1 in the cycle after E0, for exactly one cycle.
- Shift with amt=N>0 and en held high: steps occur at edges E1..EN. busy=1 from after E0 to after EN. done=1 for the single cycle after EN, with busy=0 in that cycle.
- Every en-low cycle during RUN extends busy and delays done by one cycle.
- A new start may be sampled in the same cycle done is high (back-to-back commands, zero dead cycles).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package univ_shift_pkg: op enum (op_t, 3 bits) and FSM state enum.
- One natural sub-module: shift_step, a combinational single-position shifter (q, op, si -> q_next, out_bit), reusable by other shifter blocks.
- Top level holds the state, cnt, q, so and done registers in a single async-reset always block, with next-state logic separate.

## Test plan
All scenarios use WIDTH=8.
- Reset: reset_n low mid-RUN, with q=8'hA5 and cnt=3 -> q=0, so=0, busy=0 immediately; no done after release.
- LOAD: start, op=1, d=8'h3C -> q=8'h3C after E0; done high one cycle; busy never high.
- SHL amt=3, si=1, from q=8'h81 -> q=8'h0F after E3; so=0; busy for 3 cycles; done in cycle 4.
- ROR amt=9 from q=8'h01 -> q=8'h80 after E9; so=1.
- ASR amt=2 from 8'h90, with en low for two cycles mid-run -> q=8'hE4; busy for 4 cycles. A start during busy is ignored.
- Back-to-back: LOAD 8'hFF issued in the done cycle of a previous SHR -> q=8'hFF one edge later, done pulses again; amt=0 SHR leaves q unchanged and pulses done.

Source files
------------

// File: rtl/univ_shift_pkg.sv
// Shared types for the universal shift register family: command codes,
// controller states and a small command-classification helper.
package univ_shift_pkg;

    // Command codes carried on the 3-bit op input; code 7 is unnamed and acts as HOLD
    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_LOAD = 3'd1,
        OP_SHL  = 3'd2,
        OP_SHR  = 3'd3,
        OP_ROL  = 3'd4,
        OP_ROR  = 3'd5,
        OP_ASR  = 3'd6
    } op_t;

    // Controller states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // True for the commands that run one bit-position per enabled clock
    function automatic logic is_shift_op(input logic [2:0] code);
        return (code >= 3'd2) && (code <= 3'd6);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shifter: one step of SHL/SHR/ROL/ROR/ASR.
// Non-shift codes pass the word through and report a zero out bit.
module shift_step
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  op_t              op,
    input  logic             si,
    output logic [WIDTH-1:0] q_next,
    output logic             out_bit
);

    // Select the shifted word and the bit that falls off the end
    always_comb begin
        q_next  = q;
        out_bit = 1'b0;
        case (op)
            OP_SHL: begin
                q_next  = {q[WIDTH-2:0], si};
                out_bit = q[WIDTH-1];
            end
            OP_SHR: begin
                q_next  = {si, q[WIDTH-1:1]};
                out_bit = q[0];
            end
            OP_ROL: begin
                q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
                out_bit = q[WIDTH-1];
            end
            OP_ROR: begin
                q_next  = {q[0], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            OP_ASR: begin
                q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            default: begin
                q_next  = q;
                out_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load plus multi-cycle shift/rotate
// commands stepped one position per enabled clock, with busy/done handshake.
// Every output comes straight from a flop.
module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] d,
    input  logic             si,
    output logic [WIDTH-1:0] q,
    output logic             so,
    output logic             busy,
    output logic             done
);

    state_t           state, state_nxt;
    op_t              op_run, op_run_nxt;
    logic [AMT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             so_nxt;
    logic             done_nxt;
    logic             busy_nxt;

    logic [WIDTH-1:0] step_q;
    logic             step_bit;

    // One bit-position of the latched command, applied to the current word
    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q       (q),
        .op      (op_run),
        .si      (si),
        .q_next  (step_q),
        .out_bit (step_bit)
    );

    // Next-state logic: command decode in IDLE, stepping and countdown in RUN
    always_comb begin
        state_nxt  = state;
        op_run_nxt = op_run;
        cnt_nxt    = cnt;
        q_nxt      = q;
        so_nxt     = so;
        done_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (op == OP_LOAD) begin
                        q_nxt    = d;
                        done_nxt = 1'b1;
                    end else if (is_shift_op(op) && (amt != '0)) begin
                        op_run_nxt = op_t'(op);
                        cnt_nxt    = amt;
                        state_nxt  = ST_RUN;
                    end else begin
                        // HOLD, unused codes and zero-length shifts complete at once
                        done_nxt = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // en low freezes the command; start is ignored while running
                if (en) begin
                    q_nxt   = step_q;
                    so_nxt  = step_bit;
                    cnt_nxt = cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1)) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        busy_nxt = (state_nxt == ST_RUN);
    end

    // All state and output registers; reset abandons any command without a done
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            op_run <= OP_HOLD;
            cnt    <= '0;
            q      <= '0;
            so     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            op_run <= op_run_nxt;
            cnt    <= cnt_nxt;
            q      <= q_nxt;
            so     <= so_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
        end
    end

endmodule
